ticket_vendor_ctrl: RTL and testbench

- Payment and dispense controller directly downstream of dest_selector.
- Latches the quoted order (total price, ticket count), accumulates inserted coins, then hands out tickets one at a time to the printer and returns change.
- Also supports cancel with full refund.
- One FSM plus a coin accumulator; all outputs are registered.

---
 rtl/ticket_vendor_ctrl_pkg.sv | 15 +
 rtl/ticket_vendor_ctrl_coin_accumulator.sv | 43 ++++
 rtl/ticket_vendor_ctrl.sv | 115 +++++++++++
 tb/tb_ticket_vendor_ctrl.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/ticket_vendor_ctrl_pkg.sv
// rtl/ticket_vendor_ctrl_pkg.sv - shared state encoding and limits for the ticket vendor
package ticket_vendor_ctrl_pkg;

    localparam int DW_DEFAULT  = 8;
    localparam int MAX_TICKETS = 4;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PAY      = 3'd1,
        ST_DISPENSE = 3'd2,
        ST_CHANGE   = 3'd3,
        ST_REFUND   = 3'd4
    } state_t;

endpackage

// File: rtl/ticket_vendor_ctrl_coin_accumulator.sv
// rtl/ticket_vendor_ctrl_coin_accumulator.sv - running coin total with overflow refusal and reject pulse
module ticket_vendor_ctrl_coin_accumulator
    import ticket_vendor_ctrl_pkg::*;
#(
    parameter int DW = DW_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_clear,
    input  logic          i_accept,
    input  logic          i_coin_valid,
    input  logic [DW-1:0] i_coin_value,
    output logic [DW-1:0] o_paid,
    output logic          o_coin_reject
);

    logic [DW-1:0] r_paid;
    logic          r_coin_reject;
    logic [DW:0]   w_sum;
    logic          w_overflow;

    assign w_sum      = {1'b0, r_paid} + {1'b0, i_coin_value};
    assign w_overflow = w_sum[DW];

    // Any coin not accepted into the total is physically returned one cycle later.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_paid        <= '0;
            r_coin_reject <= 1'b0;
        end else begin
            r_coin_reject <= i_coin_valid && !(i_accept && !w_overflow);
            if (i_clear) begin
                r_paid <= '0;
            end else if (i_coin_valid && i_accept && !w_overflow) begin
                r_paid <= w_sum[DW-1:0];
            end
        end
    end

    assign o_paid        = r_paid;
    assign o_coin_reject = r_coin_reject;

endmodule

// File: rtl/ticket_vendor_ctrl.sv
// rtl/ticket_vendor_ctrl.sv - payment, ticket dispense and change/refund controller
module ticket_vendor_ctrl
    import ticket_vendor_ctrl_pkg::*;
#(
    parameter int DW = DW_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] total,
    input  logic [DW-1:0] ticket,
    input  logic          order_load,
    input  logic          coin_valid,
    input  logic [DW-1:0] coin_value,
    input  logic          cancel,
    output logic          coin_reject,
    output logic          tkt_valid,
    input  logic          tkt_ready,
    output logic          chg_valid,
    output logic [DW-1:0] chg_amount,
    input  logic          chg_ready,
    output logic [DW-1:0] paid,
    output logic          busy
);

    state_t        r_state, w_state_next;
    logic [DW-1:0] r_price, r_tkts, r_chg_amount;
    logic          r_tkt_valid, r_chg_valid, r_busy;
    logic [DW-1:0] w_paid, w_chg_amount_next;
    logic          w_tkt_valid_next, w_chg_valid_next, w_busy_next;
    logic          w_load_ok, w_tkt_hs, w_chg_hs, w_paid_enough, w_clear, w_accept;

    assign w_load_ok     = order_load && (total != '0) && (ticket != '0);
    assign w_tkt_hs      = r_tkt_valid && tkt_ready;
    assign w_chg_hs      = r_chg_valid && chg_ready;
    assign w_paid_enough = (w_paid >= r_price);
    assign w_clear       = ((r_state == ST_IDLE) && w_load_ok) || w_chg_hs;
    assign w_accept      = (r_state == ST_PAY) && !cancel && !w_paid_enough;

    ticket_vendor_ctrl_coin_accumulator #(.DW(DW)) u_coin_acc (
        .clk           (clk),
        .rst           (rst),
        .i_clear       (w_clear),
        .i_accept      (w_accept),
        .i_coin_valid  (coin_valid),
        .i_coin_value  (coin_value),
        .o_paid        (w_paid),
        .o_coin_reject (coin_reject)
    );

    // Outputs are registered from the next state so they line up with r_state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_tkt_valid  <= 1'b0;
            r_chg_valid  <= 1'b0;
            r_chg_amount <= '0;
            r_busy       <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_tkt_valid  <= w_tkt_valid_next;
            r_chg_valid  <= w_chg_valid_next;
            r_chg_amount <= w_chg_amount_next;
            r_busy       <= w_busy_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_price <= '0;
            r_tkts  <= '0;
        end else if ((r_state == ST_IDLE) && w_load_ok) begin
            r_price <= total;
            r_tkts  <= ticket;
        end else if ((r_state == ST_DISPENSE) && w_tkt_hs) begin
            r_tkts  <= r_tkts - DW'(1);
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_load_ok) w_state_next = ST_PAY;
            end
            ST_PAY: begin
                if (cancel)             w_state_next = (w_paid != '0) ? ST_REFUND : ST_IDLE;
                else if (w_paid_enough) w_state_next = ST_DISPENSE;
            end
            ST_DISPENSE: begin
                if (w_tkt_hs && (r_tkts == DW'(1)))
                    w_state_next = (w_paid > r_price) ? ST_CHANGE : ST_IDLE;
            end
            ST_CHANGE, ST_REFUND: begin
                if (w_chg_hs) w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_tkt_valid_next  = (w_state_next == ST_DISPENSE);
        w_chg_valid_next  = (w_state_next == ST_CHANGE) || (w_state_next == ST_REFUND);
        w_busy_next       = (w_state_next != ST_IDLE);
        w_chg_amount_next = '0;
        if (w_state_next == ST_CHANGE)      w_chg_amount_next = w_paid - r_price;
        else if (w_state_next == ST_REFUND) w_chg_amount_next = w_paid;
    end

    assign tkt_valid  = r_tkt_valid;
    assign chg_valid  = r_chg_valid;
    assign chg_amount = r_chg_amount;
    assign paid       = w_paid;
    assign busy       = r_busy;

endmodule

// File: tb/tb_ticket_vendor_ctrl.sv
// tb/tb_ticket_vendor_ctrl.sv - directed and randomized self-checking bench for ticket_vendor_ctrl
module tb_ticket_vendor_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] total = '0, ticket = '0, coin_value = '0;
    logic       order_load = 1'b0, coin_valid = 1'b0, cancel = 1'b0;
    logic       tkt_ready = 1'b0, chg_ready = 1'b0;
    logic       coin_reject, tkt_valid, chg_valid, busy;
    logic [7:0] chg_amount, paid;

    int errors = 0;
    int checks = 0;

    ticket_vendor_ctrl #(.DW(8)) dut (
        .clk(clk), .rst(rst), .total(total), .ticket(ticket), .order_load(order_load),
        .coin_valid(coin_valid), .coin_value(coin_value), .cancel(cancel),
        .coin_reject(coin_reject), .tkt_valid(tkt_valid), .tkt_ready(tkt_ready),
        .chg_valid(chg_valid), .chg_amount(chg_amount), .chg_ready(chg_ready),
        .paid(paid), .busy(busy)
    );

    always #5 clk = ~clk;

    // Reference: customer-level bookkeeping of money and obligations.
    bit m_init = 0;
    bit m_paying = 0;
    int m_price = 0, m_paid = 0, m_order_tix = 0, m_tix = 0, m_owed = -1;
    bit m_rej = 0;
    int tkt_hs_cnt = 0, chg_hs_cnt = 0;

    initial forever begin
        @(posedge clk);
        if (tkt_valid && tkt_ready) tkt_hs_cnt++;
        if (chg_valid && chg_ready) chg_hs_cnt++;
        if (rst) begin
            m_init = 1; m_paying = 0; m_price = 0; m_paid = 0;
            m_order_tix = 0; m_tix = 0; m_owed = -1; m_rej = 0;
        end else if (m_paying) begin
            if (cancel) begin
                m_paying = 0;
                if (m_paid != 0) m_owed = m_paid;
                m_rej = coin_valid;
            end else if (m_paid >= m_price) begin
                m_paying = 0;
                m_tix = m_order_tix;
                m_rej = coin_valid;
            end else if (coin_valid) begin
                if (m_paid + int'(coin_value) > 255) m_rej = 1;
                else begin m_paid += int'(coin_value); m_rej = 0; end
            end else m_rej = 0;
        end else if (m_tix > 0) begin
            m_rej = coin_valid;
            if (tkt_ready) begin
                m_tix--;
                if (m_tix == 0 && m_paid > m_price) m_owed = m_paid - m_price;
            end
        end else if (m_owed >= 0) begin
            m_rej = coin_valid;
            if (chg_ready) begin m_owed = -1; m_paid = 0; end
        end else begin
            m_rej = coin_valid;
            if (order_load && total != 0 && ticket != 0) begin
                m_paying = 1; m_price = int'(total); m_order_tix = int'(ticket); m_paid = 0;
            end
        end
    end

    task automatic check(string name, int act, int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    initial forever begin
        @(posedge clk);
        #1;
        if (m_init) begin
            check("busy",        int'(busy),        int'(m_paying || m_tix > 0 || m_owed >= 0));
            check("tkt_valid",   int'(tkt_valid),   int'(m_tix > 0));
            check("chg_valid",   int'(chg_valid),   int'(m_owed >= 0));
            check("coin_reject", int'(coin_reject), int'(m_rej));
            check("paid",        int'(paid),        m_paid);
            if (m_owed >= 0) check("chg_amount", int'(chg_amount), m_owed);
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
        order_load = 0; coin_valid = 0; cancel = 0;
    endtask

    task automatic load(int t, int n);
        total = 8'(t); ticket = 8'(n); order_load = 1; step();
    endtask

    task automatic coin(int v);
        coin_value = 8'(v); coin_valid = 1; step();
    endtask

    task automatic wait_idle(string name, int budget);
        int n = 0;
        while (busy && n < budget) begin step(); n++; end
        if (busy) check({name, "_idle_timeout"}, 1, 0);
    endtask

    initial begin
        int t0, c0;
        rst = 1; step(); rst = 0;
        check("rst_busy", int'(busy), 0);
        check("rst_paid", int'(paid), 0);
        check("rst_chg_amount", int'(chg_amount), 0);

        // Exact payment: 12 for 3 tickets.
        tkt_ready = 1; t0 = tkt_hs_cnt; c0 = chg_hs_cnt;
        load(12, 3);
        coin(10); check("exact_paid10", int'(paid), 10);
        coin(2);  check("exact_paid12", int'(paid), 12);
        check("exact_not_yet", int'(tkt_valid), 0);
        step(); check("exact_dispense", int'(tkt_valid), 1);
        step(); check("exact_tkt2", int'(tkt_valid), 1);
        step(); check("exact_tkt3", int'(tkt_valid), 1);
        step(); check("exact_done", int'(tkt_valid), 0);
        check("exact_idle", int'(busy), 0);
        check("exact_tickets", tkt_hs_cnt - t0, 3);
        check("exact_no_chg", chg_hs_cnt - c0 + int'(chg_valid), 0);

        // Overpay: 10 paid for 6, change 4 held through backpressure.
        t0 = tkt_hs_cnt; chg_ready = 0;
        load(6, 1); coin(5); coin(5);
        begin
            int n = 0;
            while (!chg_valid && n < 10) begin step(); n++; end
        end
        check("ovp_chg_seen", int'(chg_valid), 1);
        check("ovp_amt0", int'(chg_amount), 4);
        repeat (4) begin
            step();
            check("ovp_chg_hold", int'(chg_valid), 1);
            check("ovp_amt_hold", int'(chg_amount), 4);
        end
        chg_ready = 1; step();
        check("ovp_chg_drop", int'(chg_valid), 0);
        check("ovp_idle", int'(busy), 0);
        check("ovp_paid0", int'(paid), 0);
        check("ovp_tickets", tkt_hs_cnt - t0, 1);

        // Cancel with coin in the same cycle.
        t0 = tkt_hs_cnt; chg_ready = 0;
        load(9, 2); coin(5);
        cancel = 1; coin(1);
        check("cxl_reject", int'(coin_reject), 1);
        check("cxl_refund", int'(chg_valid), 1);
        check("cxl_amount", int'(chg_amount), 5);
        chg_ready = 1; step(); chg_ready = 0;
        check("cxl_idle", int'(busy), 0);
        check("cxl_no_tickets", tkt_hs_cnt - t0, 0);

        // Stray coin in IDLE, then overflow.
        coin(3);
        check("stray_reject", int'(coin_reject), 1);
        check("stray_paid", int'(paid), 0);
        load(250, 1); coin(100); coin(100); coin(47);
        check("ovf_paid247", int'(paid), 247);
        coin(10);
        check("ovf_reject", int'(coin_reject), 1);
        check("ovf_paid_kept", int'(paid), 247);
        cancel = 1; step();
        check("ovf_refund_amt", int'(chg_amount), 247);
        chg_ready = 1; step(); chg_ready = 0;

        // Invalid and ignored loads.
        load(0, 0); check("inv_busy0", int'(busy), 0);
        load(5, 0); check("inv_busy1", int'(busy), 0);
        load(20, 1); load(3, 1); coin(5); step();
        check("ign_still_pay", int'(tkt_valid), 0);
        check("ign_busy", int'(busy), 1);
        cancel = 1; step(); chg_ready = 1; step(); chg_ready = 0;

        // Reset mid-dispense.
        tkt_ready = 0;
        load(4, 3); coin(4); step();
        check("rst_mid_dispense", int'(tkt_valid), 1);
        tkt_ready = 1; step(); tkt_ready = 0;
        rst = 1; step(); rst = 0;
        check("rstm_tkt", int'(tkt_valid), 0);
        check("rstm_busy", int'(busy), 0);
        check("rstm_paid", int'(paid), 0);
        check("rstm_chg", int'(chg_valid) + int'(chg_amount) + int'(coin_reject), 0);

        // Randomized traffic against the reference.
        for (int i = 0; i < 4000; i++) begin
            rst        = ($urandom_range(0, 599) == 0);
            order_load = ($urandom_range(0, 7) == 0);
            total      = 8'($urandom_range(0, 60));
            ticket     = 8'($urandom_range(0, 4));
            coin_valid = ($urandom_range(0, 2) == 0);
            coin_value = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(100, 255)) : 8'($urandom_range(0, 25));
            cancel     = ($urandom_range(0, 15) == 0);
            tkt_ready  = $urandom_range(0, 1);
            chg_ready  = $urandom_range(0, 1);
            step();
        end
        rst = 0; tkt_ready = 1; chg_ready = 1; cancel = 1; step();
        wait_idle("final", 20);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
